sd_sample_streamer: RTL and testbench

SD_SAMPLE_STREAMER -- requirements
Module: sd_sample_streamer

---
 rtl/sd_sample_streamer.sv | 164 ++++++++++++++++
 tb/tb_sd_sample_streamer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sample_streamer.sv
// ============================================================================
// Module      : sd_sample_streamer
// Description : Pulls SD blocks byte-wise, packs little-endian 16-bit PCM into
//               a FIFO and plays samples out at a fixed tick rate.
//               Optional macro UNDERRUN_COUNT_EN adds a saturating
//               underrun_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_sample_streamer #(
    parameter int CLK_DIV     = 1134,
    parameter int FIFO_DEPTH  = 16,
    parameter int BLOCK_BYTES = 512
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    output logic                          block_req,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    output logic                          byte_ready,
    output logic [15:0]                   sample_out,
    output logic                          sample_strobe,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
`ifdef UNDERRUN_COUNT_EN
    ,
    output logic [15:0]                   underrun_count
`endif
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BYTE = c_CNT_W'(BLOCK_BYTES - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RECV = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_armed;
    logic [c_CNT_W-1:0]   r_byte_cnt;
    logic [7:0]           r_low;
    logic [c_DIV_W-1:0]   r_div;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [15:0]          r_mem [FIFO_DEPTH];

    logic w_tick;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_accept;
    logic w_push;

    assign w_tick   = (r_div == c_DIV_LAST);
    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_pop    = w_tick && !w_empty;
    // Combinational so a full FIFO can still take a byte on the cycle it pops.
    assign byte_ready = (r_state == ST_RECV) && (!w_full || w_pop);
    assign w_accept   = byte_valid && byte_ready;
    // Odd byte count means the low byte is already held.
    assign w_push     = w_accept && r_byte_cnt[0];
    assign fill_level = r_count;

    // Block request sequencing; r_armed delays the first request after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_armed    <= 1'b0;
            r_byte_cnt <= '0;
            r_low      <= 8'h00;
            block_req  <= 1'b0;
        end else begin
            r_armed   <= 1'b1;
            block_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_armed && enable) begin
                        r_state   <= ST_REQ;
                        block_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    r_state <= ST_RECV;
                end
                ST_RECV: begin
                    if (w_accept) begin
                        if (!r_byte_cnt[0]) begin
                            r_low <= byte_data;
                        end
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_byte_cnt <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {byte_data, r_low};
    end

    // Sample-rate divider and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div         <= '0;
            sample_out    <= 16'h0000;
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            sample_strobe <= w_tick;
            underrun      <= w_tick && w_empty;
            if (w_tick) begin
                r_div      <= '0;
                sample_out <= w_empty ? 16'h0000 : r_mem[r_rd_ptr];
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

`ifdef UNDERRUN_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_count <= 16'h0000;
        end else if (w_tick && w_empty && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'h0001;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sd_sample_streamer.sv
// ============================================================================
// Module      : tb_sd_sample_streamer
// Description : Self-checking bench for sd_sample_streamer (queue-based model
//               plus directed scenarios with literal expectations).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_sample_streamer;

    localparam int CLK_DIV     = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int BLOCK_BYTES = 512;
    localparam int S_IDLE = 0, S_REQ = 1, S_RECV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        block_req;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [15:0] sample_out;
    logic        sample_strobe;
    logic        underrun;
    logic [4:0]  fill_level;
    logic [15:0] underrun_count;

    int total = 0;
    int bad   = 0;

    sd_sample_streamer #(
        .CLK_DIV     (CLK_DIV),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .BLOCK_BYTES (BLOCK_BYTES)
    ) dut (
`ifdef UNDERRUN_COUNT_EN
        .underrun_count (underrun_count),
`endif
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .block_req     (block_req),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .sample_out    (sample_out),
        .sample_strobe (sample_strobe),
        .underrun      (underrun),
        .fill_level    (fill_level)
    );

`ifndef UNDERRUN_COUNT_EN
    assign underrun_count = 16'h0000;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'((k * 37 + 11) & 255);
    endfunction

    // ---------------- behavioural model ----------------
    logic [15:0] m_q[$];
    int          m_state, m_cnt, m_div;
    logic        m_arm, m_breq, m_strobe, m_under;
    logic [7:0]  m_low;
    logic [15:0] m_sample;
    int          m_ucount;
    logic        collect = 1'b0;
    logic [15:0] got[$];

    function automatic logic m_ready();
        return (m_state == S_RECV) &&
               ((m_q.size() < FIFO_DEPTH) || (m_div == CLK_DIV - 1));
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_state = S_IDLE; m_cnt = 0; m_div = 0; m_arm = 0; m_breq = 0;
        m_strobe = 0; m_under = 0; m_low = 0; m_sample = 0; m_ucount = 0;
    endtask

    initial begin
        logic tick, acc;
        m_reset();
        forever begin
            @(negedge clk);
            if (rst) m_reset();
            chk("block_req", {31'd0, block_req}, {31'd0, m_breq});
            chk("byte_ready", {31'd0, byte_ready}, {31'd0, m_ready()});
            chk("sample_out", {16'd0, sample_out}, {16'd0, m_sample});
            chk("sample_strobe", {31'd0, sample_strobe}, {31'd0, m_strobe});
            chk("underrun", {31'd0, underrun}, {31'd0, m_under});
            chk("fill_level", {27'd0, fill_level}, 32'(m_q.size()));
`ifdef UNDERRUN_COUNT_EN
            chk("underrun_count", {16'd0, underrun_count}, 32'(m_ucount));
`endif
            if (collect && sample_strobe && !underrun) got.push_back(sample_out);
            @(posedge clk);
            if (!rst) begin
                tick = (m_div == CLK_DIV - 1);
                acc  = byte_valid && m_ready();
                if (tick) begin
                    m_strobe = 1;
                    if (m_q.size() > 0) begin
                        m_sample = m_q.pop_front();
                        m_under  = 0;
                    end else begin
                        m_sample = 0;
                        m_under  = 1;
                        if (m_ucount < 65535) m_ucount++;
                    end
                end else begin
                    m_strobe = 0;
                    m_under  = 0;
                end
                if (acc) begin
                    if (m_cnt % 2 == 1) m_q.push_back({byte_data, m_low});
                    else m_low = byte_data;
                end
                m_breq = 0;
                case (m_state)
                    S_IDLE: if (m_arm && enable) begin m_state = S_REQ; m_breq = 1; end
                    S_REQ:  m_state = S_RECV;
                    default: if (acc) begin
                        if (m_cnt == BLOCK_BYTES - 1) begin m_cnt = 0; m_state = S_IDLE; end
                        else m_cnt++;
                    end
                endcase
                m_arm = 1;
                m_div = tick ? 0 : m_div + 1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        logic found;
        found = 0;
        @(posedge clk); #1;
        byte_valid = 1; byte_data = b;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (byte_ready) begin found = 1; break; end
        end
        chk("send_byte_accepted", {31'd0, found}, 32'd1);
        @(posedge clk); #1;
        byte_valid = 0;
    endtask

    task automatic wait_sample(input string name, input logic [15:0] exp);
        logic found;
        found = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sample_strobe && !underrun) begin found = 1; break; end
        end
        chk({name, "_strobe_seen"}, {31'd0, found}, 32'd1);
        chk({name, "_value"}, {16'd0, sample_out}, {16'd0, exp});
    endtask

    initial begin
        int pulses, k, max_fill;
        logic seen_ready, seen_stall, acc, found;
        logic [15:0] uc0;
        logic [15:0] exp_q[$];

        rst = 1; enable = 0; byte_valid = 0; byte_data = 8'h00;
        repeat (3) @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_sample_out", {16'd0, sample_out}, 32'd0);
        chk("rst_fill_level", {27'd0, fill_level}, 32'd0);
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_block_req", {31'd0, block_req}, 32'd0);

        // one request, then RECV opens byte_ready; at least 2 cycles after reset
        @(posedge clk); #1 enable = 1;
        pulses = 0; seen_ready = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (block_req) begin
                pulses++;
                chk("first_req_not_before_2_cycles", {31'd0, n >= 1}, 32'd1);
            end
            if (pulses > 0 && byte_ready) seen_ready = 1;
        end
        chk("req_pulses", 32'(pulses), 32'd1);
        chk("ready_in_recv", {31'd0, seen_ready}, 32'd1);

        collect = 1;
        send_byte(8'h34);
        send_byte(8'h12);
        @(negedge clk);
        chk("fill_after_pair", {27'd0, fill_level}, 32'd1);
        wait_sample("first_sample", 16'h1234);
        chk("fill_after_pop", {27'd0, fill_level}, 32'd0);

        // empty FIFO: three ticks, three underruns
        uc0 = underrun_count;
        pulses = 0;
        for (int n = 0; n < 3 * CLK_DIV; n++) begin
            @(negedge clk);
            if (underrun) pulses++;
        end
        chk("underrun_pulses", 32'(pulses), 32'd3);
        chk("underrun_sample_zero", {16'd0, sample_out}, 32'd0);
`ifdef UNDERRUN_COUNT_EN
        chk("underrun_count_delta", 32'(underrun_count - uc0), 32'd3);
`endif

        // rest of the block with byte_valid held high; enable dropped mid-block
        @(posedge clk); #1;
        enable = 0; byte_valid = 1; k = 2; byte_data = pat(k);
        max_fill = 0; seen_stall = 0;
        for (int n = 0; n < 8000 && k < BLOCK_BYTES; n++) begin
            @(negedge clk);
            acc = byte_ready;
            if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
            if (!byte_ready) seen_stall = 1;
            @(posedge clk); #1;
            if (acc) begin k++; byte_data = pat(k); end
        end
        byte_valid = 0;
        chk("all_block_bytes_sent", 32'(k), 32'(BLOCK_BYTES));
        chk("max_fill", 32'(max_fill), 32'(FIFO_DEPTH));
        chk("ready_stalled_when_full", {31'd0, seen_stall}, 32'd1);

        found = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (fill_level == 0) begin found = 1; break; end
        end
        chk("drained", {31'd0, found}, 32'd1);
        repeat (2 * CLK_DIV) @(negedge clk);
        collect = 0;

        exp_q.push_back(16'h1234);
        for (int i = 1; i < BLOCK_BYTES / 2; i++) exp_q.push_back({pat(2 * i + 1), pat(2 * i)});
        chk("word_count", 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk("word_order", {16'd0, got[i]}, {16'd0, exp_q[i]});

        // reset in the middle of a block
        @(posedge clk); #1 enable = 1;
        found = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (block_req) begin found = 1; break; end
        end
        chk("second_req", {31'd0, found}, 32'd1);
        for (int i = 0; i <= 101; i++) send_byte(8'(i ^ 8'h5C));
        rst = 1;
        #1;
        chk("async_rst_sample_out", {16'd0, sample_out}, 32'd0);
        chk("async_rst_fill", {27'd0, fill_level}, 32'd0);
        chk("async_rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("async_rst_strobe", {31'd0, sample_strobe}, 32'd0);
        chk("async_rst_underrun", {31'd0, underrun}, 32'd0);
        chk("async_rst_ucount", {16'd0, underrun_count}, 32'd0);
        repeat (2) @(posedge clk); #1 rst = 0;
        found = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (block_req) begin found = 1; break; end
        end
        chk("req_after_rst", {31'd0, found}, 32'd1);
        send_byte(8'hA5);
        send_byte(8'h5A);
        wait_sample("fresh_block_sample", 16'h5AA5);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
